// File: rtl/cpu_mem_sequencer.sv
// cpu_mem_sequencer
// Turns one CPU memory request into two back-to-back SDRAM controller
// transactions: an instruction read at pc, then a data read or write at
// data_addr. The fetched instruction and the data-phase result are kept
// in registers and presented to the CPU.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pc, data_addr       CPU instruction / data addresses
//   data_in, write_en   CPU store data and store select
//   instr, read_data    last fetched instruction / data result (registered)
//   dram_addr           controller address (CPU address zero-extended)
//   dram_write_en       controller write request
//   dram_data_in        controller write data
//   dram_refresh_data   controller request level
//   dram_read_data      controller read data
//   dram_data_ready     one-cycle transaction-done pulse
module cpu_mem_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DRAM_ADDR_W = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      pc,
  input  logic [ADDR_W-1:0]      data_addr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   write_en,
  output logic [DATA_W-1:0]      instr,
  output logic [DATA_W-1:0]      read_data,
  output logic [DRAM_ADDR_W-1:0] dram_addr,
  output logic                   dram_write_en,
  output logic [DATA_W-1:0]      dram_data_in,
  output logic                   dram_refresh_data,
  input  logic [DATA_W-1:0]      dram_read_data,
  input  logic                   dram_data_ready
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FETCH_INSTR = 3'd1;
  localparam logic [2:0] S_WAIT        = 3'd2;
  localparam logic [2:0] S_INSTR_OUT   = 3'd3;
  localparam logic [2:0] S_DATA_OUT    = 3'd4;

  localparam int PAD_W = DRAM_ADDR_W - ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              got_instr_q, got_instr_d;
  logic [ADDR_W-1:0] snap_pc_q, snap_pc_d;
  logic [ADDR_W-1:0] snap_daddr_q, snap_daddr_d;
  logic [DATA_W-1:0] snap_din_q, snap_din_d;
  logic              snap_we_q, snap_we_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              req_changed_s;

  // A new sequence is started only when the live request differs from the
  // one last serviced, so a held request is executed exactly once.
  assign req_changed_s = (pc != snap_pc_q) || (data_addr != snap_daddr_q) ||
                         (data_in != snap_din_q) || (write_en != snap_we_q);

  // Next-state and register-update logic of the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    got_instr_d  = got_instr_q;
    snap_pc_d    = snap_pc_q;
    snap_daddr_d = snap_daddr_q;
    snap_din_d   = snap_din_q;
    snap_we_d    = snap_we_q;
    instr_d      = instr_q;
    read_data_d  = read_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_changed_s) begin
          state_d      = S_FETCH_INSTR;
          snap_pc_d    = pc;
          snap_daddr_d = data_addr;
          snap_din_d   = data_in;
          snap_we_d    = write_en;
          got_instr_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_INSTR: state_d = S_WAIT;
      S_WAIT: begin
        // got_instr tells which of the two transactions this ready closes.
        if (dram_data_ready) begin
          if (!got_instr_q) begin
            instr_d     = dram_read_data;
            got_instr_d = 1'b1;
            state_d     = S_INSTR_OUT;
          end else begin
            read_data_d = dram_read_data;
            state_d     = S_DATA_OUT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_INSTR_OUT: state_d = S_WAIT;
      S_DATA_OUT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Controller request outputs, decoded from state and the snapshot only so
  // that input changes mid-sequence never reach the controller.
  always_comb begin
    dram_refresh_data = 1'b0;
    dram_addr         = {{PAD_W{1'b0}}, snap_pc_q};
    dram_write_en     = 1'b0;
    case (state_q)
      S_FETCH_INSTR: begin
        dram_refresh_data = 1'b1;
      end
      S_WAIT: begin
        dram_refresh_data = 1'b1;
        if (got_instr_q) begin
          dram_addr     = {{PAD_W{1'b0}}, snap_daddr_q};
          dram_write_en = snap_we_q;
        end else begin
          dram_addr     = {{PAD_W{1'b0}}, snap_pc_q};
          dram_write_en = 1'b0;
        end
      end
      S_INSTR_OUT: begin
        dram_refresh_data = 1'b1;
        dram_addr         = {{PAD_W{1'b0}}, snap_daddr_q};
        dram_write_en     = snap_we_q;
      end
      default: begin
        dram_refresh_data = 1'b0;
      end
    endcase
  end

  assign dram_data_in = snap_din_q;
  assign instr        = instr_q;
  assign read_data    = read_data_q;

  // State, snapshot and result registers; reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      got_instr_q  <= 1'b0;
      snap_pc_q    <= '0;
      snap_daddr_q <= '0;
      snap_din_q   <= '0;
      snap_we_q    <= 1'b0;
      instr_q      <= '0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      got_instr_q  <= got_instr_d;
      snap_pc_q    <= snap_pc_d;
      snap_daddr_q <= snap_daddr_d;
      snap_din_q   <= snap_din_d;
      snap_we_q    <= snap_we_d;
      instr_q      <= instr_d;
      read_data_q  <= read_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// tb_cpu_mem_sequencer
// Bench for cpu_mem_sequencer: a small SDRAM controller model answers the
// requests, and a word-array reference memory predicts instr / read_data
// for directed and random CPU requests.
module tb_cpu_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0, data_addr = 16'h0, data_in = 16'h0;
  logic        write_en = 1'b0;
  logic [15:0] instr, read_data, dram_data_in;
  logic [24:0] dram_addr;
  logic        dram_write_en, dram_refresh_data;
  logic [15:0] dram_read_data;
  logic        dram_data_ready;

  int compared = 0;
  int mismatched = 0;

  cpu_mem_sequencer dut (
    .clk(clk), .rst(rst), .pc(pc), .data_addr(data_addr), .data_in(data_in),
    .write_en(write_en), .instr(instr), .read_data(read_data),
    .dram_addr(dram_addr), .dram_write_en(dram_write_en),
    .dram_data_in(dram_data_in), .dram_refresh_data(dram_refresh_data),
    .dram_read_data(dram_read_data), .dram_data_ready(dram_data_ready)
  );

  always #5 clk = ~clk;

  // Controller model: 256-word memory aliased on the low address byte.
  logic [15:0] cmem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h0;
  logic [15:0] ld_data = 16'h0;
  logic        c_busy, c_hold, c_we;
  logic [4:0]  c_cnt;
  logic [24:0] c_addr;
  logic [15:0] c_din;

  // Transaction engine: read ready 5 cycles after request seen, write 12.
  always @(posedge clk) begin
    if (ld_en) cmem[ld_addr] <= ld_data;
    if (rst) begin
      c_busy <= 1'b0; c_hold <= 1'b0; c_cnt <= 5'd0;
      dram_data_ready <= 1'b0; dram_read_data <= 16'h0;
    end else begin
      dram_data_ready <= 1'b0;
      if (c_busy) begin
        if (c_cnt == 5'd1) begin
          c_busy <= 1'b0; c_hold <= 1'b1; dram_data_ready <= 1'b1;
          if (c_we) begin
            cmem[c_addr[7:0]] <= c_din;
            dram_read_data <= c_din;
          end else begin
            dram_read_data <= cmem[c_addr[7:0]];
          end
        end else begin
          c_cnt <= c_cnt - 5'd1;
        end
      end else if (c_hold) begin
        c_hold <= 1'b0;
      end else if (dram_refresh_data) begin
        c_busy <= 1'b1; c_addr <= dram_addr; c_we <= dram_write_en;
        c_din <= dram_data_in; c_cnt <= dram_write_en ? 5'd12 : 5'd5;
      end
    end
  end

  logic [15:0] ref_mem [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issue one request and follow it through both transactions.
  task automatic run_seq(input logic [15:0] p, input logic [15:0] da,
                         input logic [15:0] din, input logic we,
                         input logic disturb, input logic [15:0] exp_instr,
                         input logic [15:0] exp_rd);
    int n;
    int cyc;
    @(negedge clk);
    pc = p; data_addr = da; data_in = din; write_en = we;
    @(posedge clk); #1;
    cyc = 1;
    check("fetch_refresh", {31'd0, dram_refresh_data}, 32'd1);
    check("fetch_addr", {7'd0, dram_addr}, {16'd0, p});
    check("fetch_we", {31'd0, dram_write_en}, 32'd0);
    @(negedge clk);
    if (disturb) begin
      pc = ~p; data_addr = ~da; data_in = ~din; write_en = ~we;
    end
    n = 0;
    while (!dram_data_ready && n < 40) begin
      @(posedge clk); #1; n++; cyc++;
    end
    check("instr_ready_timeout", {31'd0, dram_data_ready}, 32'd1);
    @(posedge clk); #1; cyc++;
    check("data_refresh", {31'd0, dram_refresh_data}, 32'd1);
    check("data_addr", {7'd0, dram_addr}, {16'd0, da});
    check("data_we", {31'd0, dram_write_en}, {31'd0, we});
    check("data_din", {16'd0, dram_data_in}, {16'd0, din});
    check("instr_early", {16'd0, instr}, {16'd0, exp_instr});
    n = 0;
    while (!dram_data_ready && n < 40) begin
      @(posedge clk); #1; n++; cyc++;
    end
    check("data_ready_timeout", {31'd0, dram_data_ready}, 32'd1);
    @(negedge clk);
    pc = p; data_addr = da; data_in = din; write_en = we;
    @(posedge clk); #1; cyc++;
    check("dout_refresh", {31'd0, dram_refresh_data}, 32'd0);
    check("dout_instr", {16'd0, instr}, {16'd0, exp_instr});
    check("dout_read_data", {16'd0, read_data}, {16'd0, exp_rd});
    check("seq_within_cpu_cycle", {31'd0, (cyc <= 64)}, 32'd1);
    // Unchanged request must not start another sequence.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dram_refresh_data) n++;
    end
    check("no_retrigger", n, 0);
    if (we) ref_mem[da[7:0]] = din;
  endtask

  initial begin
    int n;
    logic [15:0] rp, rda, rdin, ei, er;
    logic rwe, rdis;
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] rp, rda, rdin, ei, er;
    logic rwe, rdis;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_instr", {16'd0, instr}, 32'd0);
    check("reset_read_data", {16'd0, read_data}, 32'd0);
    check("reset_refresh", {31'd0, dram_refresh_data}, 32'd0);

    // Zero request equals the reset snapshot: 100 us of idle.
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (dram_refresh_data || instr != 16'h0) n++;
    end
    check("idle_hold_100us", n, 0);

    for (int i = 0; i < 256; i++) load(i[7:0], 16'($urandom));
    load(8'd1, 16'h0009); load(8'd2, 16'h0049); load(8'd3, 16'h4809);
    load(8'd4, 16'h47C9); load(8'd5, 16'hE000);

    run_seq(16'd1, 16'd2, 16'h0000, 1'b0, 1'b0, 16'h0009, 16'h0049);
    run_seq(16'd3, 16'd4, 16'h0000, 1'b0, 1'b0, 16'h4809, 16'h47C9);
    repeat (64) @(posedge clk);
    #1;
    check("hold_instr", {16'd0, instr}, 32'h4809);
    check("hold_read_data", {16'd0, read_data}, 32'h47C9);
    run_seq(16'd5, 16'd0, 16'hABAB, 1'b1, 1'b0, 16'hE000, 16'hABAB);
    check("mem0_written", {16'd0, cmem[0]}, 32'hABAB);
    run_seq(16'd0, 16'd5, 16'hABAB, 1'b0, 1'b0, 16'hABAB, 16'hE000);
    run_seq(16'd3, 16'd7, 16'hCDCD, 1'b1, 1'b1, 16'h4809, 16'hCDCD);

    // Random requests against the reference memory.
    for (int k = 0; k < 30; k++) begin
      rp = 16'($urandom); rda = 16'($urandom); rdin = 16'($urandom);
      rwe = 1'($urandom_range(0, 1)); rdis = 1'($urandom_range(0, 1));
      if (rp == pc && rda == data_addr && rdin == data_in && rwe == write_en) rp = ~rp;
      ei = ref_mem[rp[7:0]];
      er = rwe ? rdin : ref_mem[rda[7:0]];
      run_seq(rp, rda, rdin, rwe, rdis, ei, er);
    end

    // Reset while waiting on the instruction transaction.
    @(negedge clk);
    pc = 16'h0011; data_addr = 16'h0022; data_in = 16'h1234; write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, dram_refresh_data}, 32'd1);
    @(negedge clk);
    rst = 1'b1; pc = 16'h0; data_addr = 16'h0; data_in = 16'h0;
    @(posedge clk); #1;
    check("midreset_refresh", {31'd0, dram_refresh_data}, 32'd0);
    check("midreset_instr", {16'd0, instr}, 32'd0);
    check("midreset_read_data", {16'd0, read_data}, 32'd0);
    check("midreset_addr", {7'd0, dram_addr}, 32'd0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dram_refresh_data) n++;
    end
    check("post_reset_idle", n, 0);
    run_seq(16'd1, 16'd4, 16'h0000, 1'b0, 1'b0, ref_mem[1], ref_mem[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
